serial_add_arbiter: RTL and testbench

Shares one bit-serial full-adder datapath between two requesters. Each accepted request adds two WIDTH-bit operands LSB-first, one bit per clock, through a single `full_adder` instance with a registered carry. The block returns the sum, carry-out and requester ID on a held response port. It sits between the operand-producing logic and the register write-back path, and trades latency for a one-bit adder footprint.

---
 rtl/serial_add_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_serial_add_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end sharing one bit-serial full adder (LSB first, registered carry).
// Optional subtract support is built only when SERIAL_ADD_ARBITER_SUB_EN is defined.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_d;
    logic [CW-1:0]     cnt_q;
    logic              carry_q, last_grant_q;
    logic              rsp_valid_q, rsp_id_q, rsp_cout_q;
    logic [WIDTH-1:0]  rsp_sum_q;

    logic              grant_s, accept_s;
    logic [WIDTH-1:0]  sel_a_s, sel_b_s, eff_b_s;
    logic              sel_cin_s, eff_cin_s;
    logic              fa_sum_s, fa_cout_s;

    // Round-robin grant and operand selection for the requester that would be accepted.
    always_comb begin
        grant_s   = 1'b0;
        sel_a_s   = req0_a;
        sel_b_s   = req0_b;
        sel_cin_s = req0_cin;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if (grant_s) begin
            sel_a_s   = req1_a;
            sel_b_s   = req1_b;
            sel_cin_s = req1_cin;
        end else begin
            sel_a_s   = req0_a;
            sel_b_s   = req0_b;
            sel_cin_s = req0_cin;
        end
    end

`ifdef SERIAL_ADD_ARBITER_SUB_EN
    logic sel_sub_s;
    // Subtraction is a + ~b + 1; the caller's carry-in is ignored.
    always_comb begin
        sel_sub_s = grant_s ? req1_sub : req0_sub;
        if (sel_sub_s) begin
            eff_b_s   = ~sel_b_s;
            eff_cin_s = 1'b1;
        end else begin
            eff_b_s   = sel_b_s;
            eff_cin_s = sel_cin_s;
        end
    end
`else
    logic unused_sub_s;
    assign unused_sub_s = req0_sub ^ req1_sub;
    assign eff_b_s      = sel_b_s;
    assign eff_cin_s    = sel_cin_s;
`endif

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant_s;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant_s;
    assign accept_s   = req0_ready || req1_ready;

    full_adder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_sum_s),
        .co_o (fa_cout_s)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at index 0.
    always_comb begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_sum_s;
    end

    // Control FSM with datapath shift registers and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            sum_q        <= {WIDTH{1'b0}};
            carry_q      <= 1'b0;
            cnt_q        <= {CW{1'b0}};
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= {WIDTH{1'b0}};
            rsp_cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        a_q          <= sel_a_s;
                        b_q          <= eff_b_s;
                        carry_q      <= eff_cin_s;
                        cnt_q        <= {CW{1'b0}};
                        last_grant_q <= grant_s;
                        rsp_id_q     <= grant_s;
                        state_q      <= SHIFT;
                    end else begin
                        state_q      <= IDLE;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_cout_s;
                    sum_q   <= sum_d;
                    cnt_q   <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        rsp_sum_q   <= sum_d;
                        rsp_cout_q  <= fa_cout_s;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q     <= SHIFT;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= DONE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter (WIDTH=8): directed requests, monitor pops expected responses.
module tb_serial_add_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_cin, req0_sub;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin, req1_sub;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0] rsp_sum;

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got id=%0d sum=%0h cout=%0d expected no response",
                         rsp_id, rsp_sum, rsp_cout);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_id",   {31'd0, rsp_id},   {31'd0, mon_e.id});
                check("rsp_sum",  {24'd0, rsp_sum},  {24'd0, mon_e.sum});
                check("rsp_cout", {31'd0, rsp_cout}, {31'd0, mon_e.cout});
            end
        end
    end

    task automatic do_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input bit push,
                          input logic [W-1:0] es, input logic ec, output int acc_cyc);
        bit found;
        if (id) begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1'b1;
        end
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                found = 1'b1;
                break;
            end
        end
        check("grant_seen", {31'd0, found}, 32'd1);
        if (push) sb_q.push_back('{id: id, sum: es, cout: ec});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (rsp_valid) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc, n, c0;
        int   acc_c[4];
        bit   found;
        logic [W-1:0] s_exp;
        logic         c_exp;

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_cin = 1'b0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0; req1_sub = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_sum",   {24'd0, rsp_sum},   32'd0);
        check("rst_cout",  {31'd0, rsp_cout},  32'd0);
        check("rst_id",    {31'd0, rsp_id},    32'd0);
        check("rst_rdy0",  {31'd0, req0_ready}, 32'd0);
        check("rst_rdy1",  {31'd0, req1_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

        // Plain add and latency
        do_req(1'b0, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h4B, 1'b0, acc);
        wait_rsp(n);
        check("latency_add", n, 32'd8);
        repeat (3) @(posedge clk);
        #1;

        // Carry out from requester 1
        do_req(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, acc);
        wait_rsp(n);
        check("latency_carry", n, 32'd8);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: result held, no acceptance until handshake
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, acc);
        wait_rsp(n);
        check("latency_bp", n, 32'd8);
        req1_a = 8'hA5; req1_b = 8'h5A; req1_cin = 1'b1; req1_sub = 1'b0; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid},  32'd1);
            check("bp_sum",   {24'd0, rsp_sum},    32'h46);
            check("bp_cout",  {31'd0, rsp_cout},   32'd0);
            check("bp_id",    {31'd0, rsp_id},     32'd0);
            check("bp_rdy1",  {31'd0, req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        rsp_ready = 1'b1;
        do_req(1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, acc);
        check("bp_accept_gap", acc - c0, 32'd2);
        wait_rsp(n);
        repeat (3) @(posedge clk);
        #1;

        // Round-robin with both requesters always valid
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_a = 8'h01; req0_b = 8'h02; req0_cin = 1'b0; req0_sub = 1'b0;
        req1_a = 8'h10; req1_b = 8'h20; req1_cin = 1'b1; req1_sub = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{id: k[0], sum: (k[0] ? 8'h31 : 8'h03), cout: 1'b0});
        end
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    found = 1'b1;
                    break;
                end
            end
            check("arb_seen",  {31'd0, found},      32'd1);
            check("arb_grant", {31'd0, req1_ready}, {31'd0, k[0]});
            @(posedge clk);
            #1;
            acc_c[k] = cyc;
            if (k > 0) check("arb_spacing", acc_c[k] - acc_c[k-1], 32'd10);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(n);
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a shift discards the operation
        do_req(1'b1, 8'h77, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_id",  {31'd0, rsp_id},  32'd1);
        check("pre_rst_sum", {24'd0, rsp_sum}, 32'h31);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_sum",   {24'd0, rsp_sum},   32'd0);
        check("rst_mid_cout",  {31'd0, rsp_cout},  32'd0);
        check("rst_mid_id",    {31'd0, rsp_id},    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        do_req(1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, acc);
        wait_rsp(n);
        check("latency_post_rst", n, 32'd8);
        repeat (3) @(posedge clk);
        #1;

        // Subtract select
`ifdef SERIAL_ADD_ARBITER_SUB_EN
        s_exp = 8'hFE; c_exp = 1'b0;
`else
        s_exp = 8'h0C; c_exp = 1'b0;
`endif
        do_req(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1, s_exp, c_exp, acc);
        wait_rsp(n);
        repeat (3) @(posedge clk);
        #1;
`ifdef SERIAL_ADD_ARBITER_SUB_EN
        s_exp = 8'h02; c_exp = 1'b1;
`else
        s_exp = 8'h0C; c_exp = 1'b0;
`endif
        do_req(1'b1, 8'h07, 8'h05, 1'b0, 1'b1, 1'b1, s_exp, c_exp, acc);
        wait_rsp(n);
        repeat (3) @(posedge clk);
        #1;

        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
